// File: rtl/window_assembler.sv
// Collects a row-major pixel stream into a DIM x DIM window and presents it in
// parallel until the downstream window buffer loads it.
module window_assembler #(
  parameter int DATA_W = 8,
  parameter int DIM    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clr,
  input  logic [DATA_W-1:0]                      in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [0:DIM-1][0:DIM-1][DATA_W-1:0]    win_out,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [4:0]                             fill_count
);

  localparam int SLOTS = DIM * DIM;
  localparam int CNT_W = $clog2(SLOTS);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic [SLOTS-1:0][DATA_W-1:0]  slots;

  // Slot k is window position (k/DIM, k%DIM); the window is a plain register view.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      assign win_out[r][c] = slots[r*DIM + c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      slots      <= '0;
      in_ready   <= 1'b1;
      win_valid  <= 1'b0;
      fill_count <= '0;
    end else if (clr) begin
      state      <= FILL;
      cnt        <= '0;
      slots      <= '0;
      in_ready   <= 1'b1;
      win_valid  <= 1'b0;
      fill_count <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            slots[cnt] <= in_data;
            if (cnt == CNT_W'(SLOTS - 1)) begin
              // Last slot written: counter wraps only here, window goes out.
              cnt        <= '0;
              state      <= HOLD;
              in_ready   <= 1'b0;
              win_valid  <= 1'b1;
              fill_count <= 5'(SLOTS);
            end else begin
              cnt        <= cnt + 1'b1;
              fill_count <= fill_count + 5'd1;
            end
          end
        end
        HOLD: begin
          if (win_ready) begin
            state      <= FILL;
            in_ready   <= 1'b1;
            win_valid  <= 1'b0;
            fill_count <= '0;
          end
        end
        default: begin
          state      <= FILL;
          cnt        <= '0;
          in_ready   <= 1'b1;
          win_valid  <= 1'b0;
          fill_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_assembler.sv
// Scoreboard bench for window_assembler: a queue-based model predicts windows and
// per-cycle status; a negedge monitor compares against the DUT.
module tb_window_assembler;

  typedef logic [0:3][0:3][7:0] win_t;
  typedef logic [7:0] byte_q [$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  win_t       win_out;
  logic       win_valid;
  logic       win_ready = 1'b0;
  logic [4:0] fill_count;

  window_assembler #(.DATA_W(8), .DIM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic win_t pack_q(input byte_q q);
    win_t w = '0;
    for (int k = 0; k < q.size() && k < 16; k++) w[k/4][k%4] = q[k];
    return w;
  endfunction

  // Reference model: bytes of the current window, hold flag, visible storage.
  byte_q       m_buf;
  logic        m_hold = 1'b0;
  win_t        m_mem  = '0;
  win_t        exp_q [$];
  int          rises [$];
  logic        prev_wv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_buf.delete();
      m_hold <= 1'b0;
      m_mem  <= '0;
    end else if (clr) begin
      m_buf.delete();
      m_hold <= 1'b0;
      m_mem  <= '0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_mem[m_buf.size()/4][m_buf.size()%4] <= in_data;
        m_buf.push_back(in_data);
        if (m_buf.size() == 16) begin
          exp_q.push_back(pack_q(m_buf));
          m_buf.delete();
          m_hold <= 1'b1;
        end
      end
    end else if (win_ready) begin
      m_hold <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_wv <= 1'b0;
    end else begin
      chk("in_ready",   128'(in_ready),   128'(!m_hold));
      chk("win_valid",  128'(win_valid),  128'(m_hold));
      chk("fill_count", 128'(fill_count), 128'(m_hold ? 16 : m_buf.size()));
      chk("win_out",    128'(win_out),    128'(m_mem));
      if (win_valid && !prev_wv) begin
        rises.push_back(cyc);
        if (exp_q.size() == 0) chk("window_unexpected", 128'(win_out), 128'hx);
        else chk("window", 128'(win_out), 128'(exp_q.pop_front()));
      end
      prev_wv <= win_valid;
    end
  end

  task automatic send(input logic [7:0] b);
    int   tries = 0;
    logic acc   = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 64);
    if (!acc) chk("send_timeout", 128'(acc), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  win_t pat;

  initial begin
    repeat (3) tick();
    // Reset state, while rst still asserted
    chk("rst_in_ready",   128'(in_ready),   128'(1));
    chk("rst_win_valid",  128'(win_valid),  128'(0));
    chk("rst_fill_count", 128'(fill_count), 128'(0));
    chk("rst_win_out",    128'(win_out),    128'(0));
    rst = 1'b0;
    tick();

    // Back-to-back stream 0x00..0x0F
    for (int k = 0; k < 16; k++) begin
      pat[k/4][k%4] = 8'(4*(k/4) + (k%4));
      send(8'(k));
    end
    chk("stream_win_valid",  128'(win_valid),  128'(1));
    chk("stream_fill_count", 128'(fill_count), 128'(16));
    chk("stream_win_out",    128'(win_out),    128'(pat));

    // HOLD backpressure with junk input
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_win_out",  128'(win_out),  128'(pat));
    end
    in_valid  = 1'b0;
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    chk("handoff_win_valid", 128'(win_valid), 128'(0));
    chk("handoff_in_ready",  128'(in_ready),  128'(1));

    // Same bytes with gaps
    for (int k = 0; k < 16; k++) begin
      send(8'(k));
      chk("gap_fill_count", 128'(fill_count), 128'(k == 15 ? 16 : k + 1));
      tick();
    end
    chk("gap_win_out", 128'(win_out), 128'(pat));
    win_ready = 1'b1;
    tick();

    // Back-to-back windows with win_ready held high
    rises.delete();
    for (int k = 16'h10; k <= 16'h2F; k++) send(8'(k));
    tick();
    tick();
    chk("b2b_count", 128'(rises.size()), 128'(2));
    if (rises.size() >= 2) chk("b2b_spacing", 128'(rises[1] - rises[0]), 128'(17));
    win_ready = 1'b0;
    tick();

    // clr mid-fill drops the coincident byte
    for (int k = 0; k < 7; k++) send(8'($urandom));
    in_data  = 8'hA5;
    in_valid = 1'b1;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_fill_count", 128'(fill_count), 128'(0));
    chk("clr_win_out",    128'(win_out),    128'(0));
    for (int k = 0; k < 16; k++) send(8'($urandom));
    chk("clr_refill_valid", 128'(win_valid), 128'(1));
    win_ready = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      win_ready = ($urandom_range(0, 3) == 0);
      clr       = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid  = 1'b0;
    win_ready = 1'b0;
    clr       = 1'b1;
    tick();
    clr = 1'b0;

    // Async reset while holding a window
    for (int k = 0; k < 16; k++) send(8'($urandom_range(1, 255)));
    tick();
    tick();
    chk("pre_rst_win_valid", 128'(win_valid), 128'(1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_win_valid",  128'(win_valid),  128'(0));
    chk("arst_in_ready",   128'(in_ready),   128'(1));
    chk("arst_win_out",    128'(win_out),    128'(0));
    chk("arst_fill_count", 128'(fill_count), 128'(0));
    @(negedge clk);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
